// File: rtl/imem_boot_loader.sv
// Framed byte-stream loader for the instruction memory. The processor stays in reset
// until a complete image has been written and its payload XOR checksum matches.
module imem_boot_loader #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [7:0]  MAGIC      = 8'hA5,
    parameter int          MAX_WORDS  = 4096
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    input  logic                  restart,
    output logic [ADDR_WIDTH-1:0] load_address,
    output logic [31:0]           load_data,
    output logic                  load_wren,
    output logic                  proc_hold,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_HI = 3'd1,
        S_CNT_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    localparam logic [16:0] MAX_WORDS_W = 17'(MAX_WORDS);

    state_t                state_q, state_d;
    logic [7:0]            cnt_hi_q, cnt_hi_d;
    logic [15:0]           rem_q, rem_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [23:0]           asm_q, asm_d;
    logic [7:0]            xor_q, xor_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic                  wren_q, wren_d;
    logic                  hold_q, done_q, error_q;
    logic                  accept;
    logic [15:0]           n_word;

    // Byte handshake: a byte is consumed on a rising edge where byte_valid and
    // byte_ready are both high; byte_ready depends only on the current state.
    assign byte_ready = (state_q != S_DONE) && (state_q != S_ERROR);
    assign accept     = byte_valid && byte_ready;
    assign n_word     = {cnt_hi_q, byte_data};

    always_comb begin
        state_d  = state_q;
        cnt_hi_d = cnt_hi_q;
        rem_d    = rem_q;
        idx_d    = idx_q;
        bcnt_d   = bcnt_q;
        asm_d    = asm_q;
        xor_d    = xor_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wren_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && byte_data == MAGIC) begin
                    state_d = S_CNT_HI;
                    idx_d   = '0;
                    xor_d   = '0;
                    bcnt_d  = '0;
                end
            end
            S_CNT_HI: begin
                if (accept) begin
                    cnt_hi_d = byte_data;
                    state_d  = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (accept) begin
                    rem_d = n_word;
                    if ({1'b0, n_word} > MAX_WORDS_W) state_d = S_ERROR;
                    else if (n_word == 16'd0)         state_d = S_CHECK;
                    else                              state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    xor_d  = xor_q ^ byte_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        wren_d = 1'b1;
                        data_d = {asm_q, byte_data};
                        addr_d = idx_q;
                        idx_d  = idx_q + 1'b1;
                        rem_d  = rem_q - 16'd1;
                        if (rem_q == 16'd1) state_d = S_CHECK;
                    end else begin
                        asm_d = {asm_q[15:0], byte_data};
                    end
                end
            end
            S_CHECK: begin
                if (accept) state_d = (byte_data == xor_q) ? S_DONE : S_ERROR;
            end
            S_DONE, S_ERROR: begin
                if (restart) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_hi_q <= '0;
            rem_q    <= '0;
            idx_q    <= '0;
            bcnt_q   <= '0;
            asm_q    <= '0;
            xor_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            wren_q   <= 1'b0;
            hold_q   <= 1'b1;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_hi_q <= cnt_hi_d;
            rem_q    <= rem_d;
            idx_q    <= idx_d;
            bcnt_q   <= bcnt_d;
            asm_q    <= asm_d;
            xor_q    <= xor_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wren_q   <= wren_d;
            // Status flags follow the state being entered, so they switch on the same edge.
            hold_q   <= (state_d != S_DONE);
            done_q   <= (state_d == S_DONE);
            error_q  <= (state_d == S_ERROR);
        end
    end

    assign load_address = addr_q;
    assign load_data    = data_q;
    assign load_wren    = wren_q;
    assign proc_hold    = hold_q;
    assign done         = done_q;
    assign error        = error_q;
    assign dbg_state    = state_q;

endmodule
